// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: instruction field layout,
// the default halt opcode, the sequencer state type and field helpers.
package alu_seq_pkg;

  localparam int INSTR_W = 12;
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 8;
  localparam int IN1_MSB = 7;
  localparam int IN1_LSB = 4;
  localparam int IN2_MSB = 3;
  localparam int IN2_LSB = 0;

  localparam logic [3:0] DEFAULT_HALT_OP = 4'hF;

  typedef enum logic {
    RUN,
    HALTED
  } seq_state_e;

  function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [3:0] instr_in1(input logic [INSTR_W-1:0] instr);
    return instr[IN1_MSB:IN1_LSB];
  endfunction

  function automatic logic [3:0] instr_in2(input logic [INSTR_W-1:0] instr);
    return instr[IN2_MSB:IN2_LSB];
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-in / result-out handshake bundle of the ALU sequencer,
// plus its halt/restart control and issue counter.
interface alu_sequencer_if #(
  parameter int CNT_W = 8
) ();
  import alu_seq_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [3:0]         out_result;
  logic               restart;
  logic               halted;
  logic [CNT_W-1:0]   issue_count;

  modport master (
    output in_valid, in_instr, out_ready, restart,
    input  in_ready, out_valid, out_instr, out_result, halted, issue_count
  );

  modport slave (
    input  in_valid, in_instr, out_ready, restart,
    output in_ready, out_valid, out_instr, out_result, halted, issue_count
  );

endinterface

// File: rtl/alu.sv
// 4-bit combinational ALU driven by the sequencer; sixteen operations
// selected by opcode, results truncated to 4 bits.
module alu (
  input  logic [3:0] opcode,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  output logic [3:0] result
);

  always_comb begin
    result = 4'h0;
    case (opcode)
      4'h0: result = in1 + in2;
      4'h1: result = in1 - in2;
      4'h2: result = in1 & in2;
      4'h3: result = in1 | in2;
      4'h4: result = in1 ^ in2;
      4'h5: result = ~in1;
      4'h6: result = in1 << in2[1:0];
      4'h7: result = in1 >> in2[1:0];
      4'h8: result = ~(in1 & in2);
      4'h9: result = ~(in1 | in2);
      4'hA: result = ~(in1 ^ in2);
      4'hB: result = in1;
      4'hC: result = in2;
      4'hD: result = in1 + 4'h1;
      4'hE: result = in1 - 4'h1;
      default: result = 4'h0;
    endcase
  end

endmodule

// File: rtl/alu_seq_fifo.sv
// Small synchronous FIFO holding pending instruction words; pointers carry
// one extra wrap bit so full and empty can be told apart.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= data;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Buffers instruction words, issues one per cycle to the ALU and registers
// each result with its instruction; a halt opcode parks issue until restart.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter int         CNT_W   = 8,
  parameter logic [3:0] HALT_OP = DEFAULT_HALT_OP
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_sequencer_if.slave bus
);

  seq_state_e         state;
  logic               out_valid_q;
  logic [INSTR_W-1:0] out_instr_q;
  logic [3:0]         out_result_q;
  logic [CNT_W-1:0]   issue_count_q;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               head_is_halt;
  logic [INSTR_W-1:0] head;
  logic [3:0]         head_op;
  logic [3:0]         head_in1;
  logic [3:0]         head_in2;
  logic [3:0]         alu_result;

  // Acceptance depends only on registered state, never on out_ready.
  assign bus.in_ready = !full && (state == RUN);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == RUN) && !empty && (!out_valid_q || bus.out_ready);

  assign head_op      = instr_op(head);
  assign head_in1     = instr_in1(head);
  assign head_in2     = instr_in2(head);
  assign head_is_halt = (head_op == HALT_OP);

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .data  (bus.in_instr),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  alu u_alu (
    .opcode (head_op),
    .in1    (head_in1),
    .in2    (head_in2),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_result_q  <= '0;
      issue_count_q <= '0;
    end else begin
      if (pop && !head_is_halt) begin
        out_valid_q   <= 1'b1;
        out_instr_q   <= head;
        out_result_q  <= alu_result;
        issue_count_q <= issue_count_q + CNT_W'(1);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A halt pop is discarded; a pending result keeps draining normally.
      if (pop && head_is_halt) begin
        state <= HALTED;
      end else if ((state == HALTED) && bus.restart) begin
        state <= RUN;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_result  = out_result_q;
  assign bus.issue_count = issue_count_q;
  assign bus.halted      = (state == HALTED);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a driver feeds queued words, a monitor
// scores every output handshake against hand-computed results.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [11:0] instr;
    logic [3:0]  result;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  exp_t stim_q[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  int   base;

  always #5 clk = ~clk;

  alu_sequencer_if #(.CNT_W(CNT_W)) bus ();

  alu_sequencer #(
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .HALT_OP (4'hF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] instr, input logic [3:0] result);
    stim_q.push_back('{instr: instr, result: result});
  endtask

  task automatic waitAccepted(input int target, input int budget);
    for (int i = 0; i < budget && acc_cnt < target; i++) @(posedge clk);
    #1;
    checkOutput("accept_within_budget", 32'(acc_cnt >= target), 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && (stim_q.size() != 0 || sb_q.size() != 0); i++) @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("drain_within_budget", 32'(stim_q.size() + sb_q.size()), 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.restart = 1'b0;
    stim_q.delete();
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Driver: holds each queued word on in_valid until the handshake completes.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.in_valid && bus.in_ready && stim_q.size() > 0) begin
        acc_cnt++;
        if (stim_q[0].instr[11:8] != 4'hF) sb_q.push_back(stim_q[0]);
        void'(stim_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (stim_q.size() > 0) begin
        bus.in_valid = 1'b1;
        bus.in_instr = stim_q[0].instr;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
      end
    end
  end

  // Monitor: scores completed output handshakes and stability under stall.
  initial begin
    exp_t        e;
    logic        hold_v;
    logic [11:0] hold_i;
    logic [3:0]  hold_r;
    hold_v = 1'b0;
    hold_i = '0;
    hold_r = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_output: got instr %0h, expected no output", bus.out_instr);
        end else begin
          e = sb_q.pop_front();
          checkOutput("out_instr", 32'(bus.out_instr), 32'(e.instr));
          checkOutput("out_result", 32'(bus.out_result), 32'(e.result));
        end
        hold_v = 1'b0;
      end else if (bus.out_valid) begin
        if (hold_v) begin
          checkOutput("hold_instr", 32'(bus.out_instr), 32'(hold_i));
          checkOutput("hold_result", 32'(bus.out_result), 32'(hold_r));
        end
        hold_v = 1'b1;
        hold_i = bus.out_instr;
        hold_r = bus.out_result;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.out_ready = 1'b1;
    bus.restart   = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_halted", 32'(bus.halted), 32'd0);
    checkOutput("reset_issue_count", 32'(bus.issue_count), 32'd0);
    doReset();

    // Single issue and latency.
    bus.out_ready = 1'b1;
    base = acc_cnt;
    applyStimulus(12'h135, 4'hE);
    waitAccepted(base + 1, 10);
    checkOutput("lat_n_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("lat_n1_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("lat_n1_instr", 32'(bus.out_instr), 32'h135);
    checkOutput("single_issue_count", 32'(bus.issue_count), 32'd1);
    @(posedge clk); #1;
    checkOutput("lat_n2_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure and full boundary.
    doReset();
    bus.out_ready = 1'b0;
    base = acc_cnt;
    applyStimulus(12'h101, 4'hF);
    applyStimulus(12'h102, 4'hE);
    applyStimulus(12'h103, 4'hD);
    applyStimulus(12'h104, 4'hC);
    applyStimulus(12'h105, 4'hB);
    applyStimulus(12'h106, 4'hA);
    waitAccepted(base + 5, 30);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_accepted", 32'(acc_cnt - base), 32'd5);
    checkOutput("bp_out_instr", 32'(bus.out_instr), 32'h101);
    checkOutput("bp_issue_count", 32'(bus.issue_count), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("full_no_same_cycle_push", 32'(acc_cnt - base), 32'd5);
    @(posedge clk); #1;
    checkOutput("full_push_next_cycle", 32'(acc_cnt - base), 32'd6);
    waitDrain(40);
    checkOutput("bp_final_count", 32'(bus.issue_count), 32'd6);

    // HALT then restart.
    doReset();
    bus.out_ready = 1'b1;
    base = acc_cnt;
    applyStimulus(12'h135, 4'hE);
    applyStimulus(12'hF00, 4'h0);
    applyStimulus(12'h246, 4'h4);
    waitAccepted(base + 3, 20);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("halt_halted", 32'(bus.halted), 32'd1);
    checkOutput("halt_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("halt_issue_count", 32'(bus.issue_count), 32'd1);
    checkOutput("halt_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("halt_pending", 32'(sb_q.size()), 32'd1);
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
    checkOutput("restart_halted", 32'(bus.halted), 32'd0);
    waitDrain(20);
    checkOutput("restart_issue_count", 32'(bus.issue_count), 32'd2);

    // Asynchronous reset in the middle of traffic.
    doReset();
    bus.out_ready = 1'b0;
    base = acc_cnt;
    applyStimulus(12'h023, 4'h5);
    applyStimulus(12'h3A5, 4'hF);
    applyStimulus(12'h4F3, 4'hC);
    applyStimulus(12'h57F, 4'h8);
    waitAccepted(base + 4, 20);
    @(posedge clk); #1;
    checkOutput("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("pre_rst_issue_count", 32'(bus.issue_count), 32'd1);
    #2;
    rst_n = 1'b0;
    stim_q.delete();
    sb_q.delete();
    #1;
    checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_out_result", 32'(bus.out_result), 32'd0);
    checkOutput("mid_rst_out_instr", 32'(bus.out_instr), 32'd0);
    checkOutput("mid_rst_issue_count", 32'(bus.issue_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("post_rst_issue_count", 32'(bus.issue_count), 32'd0);

    // Counter wrap: 17 issues on a 4-bit counter.
    doReset();
    bus.out_ready = 1'b1;
    applyStimulus(12'h012, 4'h3);
    applyStimulus(12'h0FF, 4'hE);
    applyStimulus(12'h1A3, 4'h7);
    applyStimulus(12'h2CA, 4'h8);
    applyStimulus(12'h35A, 4'hF);
    applyStimulus(12'h4F0, 4'hF);
    applyStimulus(12'h5A0, 4'h5);
    applyStimulus(12'h632, 4'hC);
    applyStimulus(12'h7C3, 4'h1);
    applyStimulus(12'h8FF, 4'h0);
    applyStimulus(12'h900, 4'hF);
    applyStimulus(12'hA5A, 4'h0);
    applyStimulus(12'hB7E, 4'h7);
    applyStimulus(12'hC7E, 4'hE);
    applyStimulus(12'hDF0, 4'h0);
    applyStimulus(12'hE00, 4'hF);
    applyStimulus(12'h099, 4'h2);
    waitDrain(100);
    checkOutput("wrap_issue_count", 32'(bus.issue_count), 32'd1);

    // Restart while running must be ignored.
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
    checkOutput("run_restart_halted", 32'(bus.halted), 32'd0);
    checkOutput("run_restart_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("run_restart_out_valid2", 32'(bus.out_valid), 32'd0);
    checkOutput("run_restart_in_ready", 32'(bus.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
